// File: rtl/mdu_unit_pkg.sv
// Shared CPU definitions for the multiply/divide unit: operation encodings,
// default latencies and the unit's controller states.
package mdu_unit_pkg;

    // mdOp encodings, also used by the controller and the hazard unit
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    // Default busy durations for multiply and divide
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    // Controller states of the multi-cycle sequencer
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/mdu_unit.sv
// Multiply/divide unit for the EX stage. It owns the HI/LO registers and
// models multi-cycle latency with a busy flag. The result is computed at
// accept time into shadow registers and committed when the countdown expires.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = mdu_unit_pkg::MULT_CYCLES,
    parameter int DIV_CYCLES  = mdu_unit_pkg::DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       mdOp,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    md_state_e        state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hiNext;
    logic [WIDTH-1:0] loNext;
    logic             skipWrite;

    logic [WIDTH-1:0]   hiCalc;
    logic [WIDTH-1:0]   loCalc;
    logic               divZero;
    logic [2*WIDTH-1:0] sProd;
    logic [2*WIDTH-1:0] uProd;
    logic [WIDTH-1:0]   sQuot;
    logic [WIDTH-1:0]   sRem;

    // Combinational arithmetic: full-width products and guarded quotients/remainders
    always_comb begin
        sProd   = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
        uProd   = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        sQuot   = '0;
        sRem    = '0;
        hiCalc  = '0;
        loCalc  = '0;
        divZero = 1'b0;
        case (md_op_e'(mdOp))
            MD_MULT: begin
                {hiCalc, loCalc} = sProd;
            end
            MD_MULTU: begin
                {hiCalc, loCalc} = uProd;
            end
            MD_DIV: begin
                if (B == '0) begin
                    divZero = 1'b1;
                end else if (A == MIN_NEG && B == ALL_ONES) begin
                    loCalc = MIN_NEG;
                    hiCalc = '0;
                end else begin
                    sQuot  = $signed(A) / $signed(B);
                    sRem   = $signed(A) % $signed(B);
                    loCalc = sQuot;
                    hiCalc = sRem;
                end
            end
            MD_DIVU: begin
                if (B == '0) begin
                    divZero = 1'b1;
                end else begin
                    loCalc = A / B;
                    hiCalc = A % B;
                end
            end
            default: begin
            end
        endcase
    end

    // Sequencer: accepts operations while idle, counts down, commits HI/LO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= MD_IDLE;
            count     <= '0;
            busy      <= 1'b0;
            hiNext    <= '0;
            loNext    <= '0;
            skipWrite <= 1'b0;
            HI        <= '0;
            LO        <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        case (md_op_e'(mdOp))
                            MD_MULT, MD_MULTU: begin
                                hiNext    <= hiCalc;
                                loNext    <= loCalc;
                                skipWrite <= 1'b0;
                                count     <= CW'(MULT_CYCLES);
                                busy      <= 1'b1;
                                state     <= MD_RUN;
                            end
                            MD_DIV, MD_DIVU: begin
                                hiNext    <= hiCalc;
                                loNext    <= loCalc;
                                skipWrite <= divZero;
                                count     <= CW'(DIV_CYCLES);
                                busy      <= 1'b1;
                                state     <= MD_RUN;
                            end
                            MD_MTHI: HI <= A;
                            MD_MTLO: LO <= A;
                            default: begin
                            end
                        endcase
                    end
                end
                MD_RUN: begin
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        busy  <= 1'b0;
                        state <= MD_IDLE;
                        if (!skipWrite) begin
                            HI <= hiNext;
                            LO <= loNext;
                        end
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule
